// File: rtl/cdc_hs_arbiter.sv
// Round-robin arbiter sharing one source-domain CDC request/response channel among
// NUM_REQ requesters: one transfer in flight, ack or timeout per requester, then a guard gap.
module cdc_hs_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 64,
  parameter int GAP_CYCLES = 4,
  parameter int CW         = 7,
  localparam int IW        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            req_err,
  output logic                          ch_vld,
  output logic [DATA_WIDTH-1:0]         ch_din,
  input  logic                          ch_rdy,
  output logic                          busy,
  output logic [IW-1:0]                 gnt_id,
  output logic                          stray_rdy,
  input  logic                          stray_clr
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t                             state_q, state_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [IW-1:0]                      last_q, last_d, gnt_q, gnt_d, pick;
  logic [DATA_WIDTH-1:0]              din_q, din_d;
  logic [NUM_REQ-1:0]                 ack_q, ack_d, err_q, err_d;
  logic                               vld_q, vld_d, busy_q, busy_d, stray_q, stray_d;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_a;
  logic                               found;
  int                                 idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_a[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Rotating priority: first pending requester strictly after the last one served.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && req_vld[IW'(idx)]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    din_d   = din_q;
    ack_d   = '0;
    err_d   = '0;
    vld_d   = 1'b0;
    stray_d = stray_q;
    if (stray_clr) stray_d = 1'b0;
    // A ready before WAIT cannot belong to the current transfer; flag it, set wins over clear.
    if (ch_rdy && (state_q == IDLE || state_q == ISSUE)) stray_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (|req_vld) begin
          gnt_d   = pick;
          din_d   = data_a[pick];
          vld_d   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (ch_rdy) begin
          ack_d[gnt_q] = 1'b1;
          last_d       = gnt_q;
          cnt_d        = '0;
          state_d      = GAP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d[gnt_q] = 1'b1;
          last_d       = gnt_q;
          cnt_d        = '0;
          state_d      = GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        // ch_rdy deliberately ignored here so a lingering ready pulse is absorbed.
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      gnt_q   <= '0;
      din_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      stray_q <= stray_d;
    end
  end

  assign req_ack   = ack_q;
  assign req_err   = err_q;
  assign ch_vld    = vld_q;
  assign ch_din    = din_q;
  assign busy      = busy_q;
  assign gnt_id    = gnt_q;
  assign stray_rdy = stray_q;

endmodule
